// File: rtl/key_pkg.sv
// Shared constants, types and helpers for the push-button front end.
package key_pkg;

  localparam int KEY_UP      = 0;
  localparam int KEY_DOWN    = 1;
  localparam int KEY_LEFT    = 2;
  localparam int KEY_RIGHT   = 3;
  localparam int KEY_CONFIRM = 4;
  localparam int NUM_KEYS    = 5;
  localparam int NUM_DIRS    = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 15_000_000;
  localparam int DEF_CNT_W           = 26;

  typedef enum logic {
    REP_DELAY  = 1'b0,
    REP_PERIOD = 1'b1
  } rep_phase_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One-hot of the lowest set bit; lower index wins.
  function automatic logic [NUM_KEYS-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [NUM_KEYS-1:0] g;
    g = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, mismatch counter, debounced level and a
// combinational strobe asserted in the cycle before the level rises.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             expire;

  assign mismatch = sync_q ^ level;
  assign expire   = mismatch && (cnt == CNT_LAST);
  // Early strobe so the pending bit is set in the same edge the level rises.
  assign rise     = expire && !level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      if (!mismatch || expire) cnt <= '0;
      else                     cnt <= cnt + CNT_W'(1);
      if (expire) level <= ~level;
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Button front end: five debounced keys, pending-event register and fixed
// priority arbiter. Define KEY_AUTO_REPEAT_EN to add direction-key auto-repeat.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_DIRS-1:0] buttons,
  output logic                btn,
  output logic [NUM_KEYS-1:0] key_level
);

  localparam int MAX_COUNT = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  if (longint'(MAX_COUNT) > (longint'(1) << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W is too narrow for the configured cycle counts");
  end

  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] event_v;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pending_nxt;
  logic [NUM_KEYS-1:0] grant;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (key_raw[k]),
      .level(key_level[k]),
      .rise (rise[k])
    );
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0]    rep_cnt   [NUM_DIRS];
  rep_phase_e          rep_phase [NUM_DIRS];
  logic [NUM_KEYS-1:0] rep_ev;

  // Counter sits at 0 in the cycle the level first reads high.
  always_comb begin
    rep_ev = '0;
    for (int k = 0; k < NUM_DIRS; k++) begin
      rep_ev[k] = key_level[k] &&
                  (rep_cnt[k] == ((rep_phase[k] == REP_DELAY) ? DELAY_LAST : PERIOD_LAST));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIRS; k++) begin
        rep_cnt[k]   <= '0;
        rep_phase[k] <= REP_DELAY;
      end
    end else begin
      for (int k = 0; k < NUM_DIRS; k++) begin
        if (!key_level[k]) begin
          rep_cnt[k]   <= '0;
          rep_phase[k] <= REP_DELAY;
        end else if (rep_ev[k]) begin
          rep_cnt[k]   <= '0;
          rep_phase[k] <= REP_PERIOD;
        end else begin
          rep_cnt[k]   <= rep_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign event_v = rise | rep_ev;
`else
  assign event_v = rise;
`endif

  // NOTE: every signal written here gets a value on every path (defaults
  // first), so no latch is inferred.
  always_comb begin
    grant       = lowest_set(pending);
    pending_nxt = (pending & ~grant) | event_v;
  end

  // A fresh event on the granted bit survives the clear and pulses again.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      buttons <= '0;
      btn     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      buttons <= grant[NUM_DIRS-1:0];
      btn     <= grant[KEY_CONFIRM];
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen: a behavioural model checked every
// cycle plus literal timing checks. Honours KEY_AUTO_REPEAT_EN when defined.
module tb_key_pulse_gen;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int CW  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] key_raw;
  logic [3:0] buttons;
  logic       btn;
  logic [4:0] key_level;

  always #5 clk = ~clk;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .buttons  (buttons),
    .btn      (btn),
    .key_level(key_level)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: a press is a level change held for DEB synced samples;
  // events queue in a bit set and leave lowest-index first, one per cycle.
  bit [4:0] m_s1, m_s, m_lvl, m_pend, m_ev, m_out, m_old;
  bit [3:0] m_buttons;
  bit       m_btn;
  int       m_run  [5];
  int       m_held [5];
  int       m_h;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1 = '0; m_s = '0; m_lvl = '0; m_pend = '0;
      m_buttons = '0; m_btn = 1'b0;
      for (int k = 0; k < 5; k++) begin
        m_run[k]  = 0;
        m_held[k] = 0;
      end
    end else begin
      m_ev  = '0;
      m_old = m_lvl;
`ifdef KEY_AUTO_REPEAT_EN
      for (int k = 0; k < 4; k++) begin
        if (m_lvl[k]) begin
          m_h = m_held[k] + 1;
          if (m_h == RD || (m_h > RD && (m_h - RD) % RP == 0)) m_ev[k] = 1'b1;
        end
      end
`endif
      for (int k = 0; k < 5; k++) begin
        if (m_s[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_lvl[k] = ~m_lvl[k];
            m_run[k] = 0;
            if (m_lvl[k]) m_ev[k] = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
        m_held[k] = (m_old[k] && m_lvl[k]) ? m_held[k] + 1 : 0;
      end
      m_out = '0;
      for (int k = 4; k >= 0; k--) if (m_pend[k]) m_out = 5'b00001 << k;
      m_pend    = (m_pend & ~m_out) | m_ev;
      m_buttons = m_out[3:0];
      m_btn     = m_out[4];
      m_s       = m_s1;
      m_s1      = key_raw;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_buttons", buttons, m_buttons);
      check("model_btn", btn, m_btn);
      check("model_key_level", key_level, m_lvl);
      if (buttons != 0 && btn) check("one_hot_out", 1, 0);
    end
  end

  int n, first;
  int pulse_at[$];

  initial begin
    rst     = 1'b1;
    key_raw = '0;
    step(3);
    cmp_en = 1'b1;
    check("rst_buttons", buttons, 4'b0000);
    check("rst_btn", btn, 1'b0);
    check("rst_key_level", key_level, 5'b00000);
    rst = 1'b0;
    step(2);

    // 1: clean up press
    key_raw[0] = 1'b1;
    step(5);
    check("t1_level_c5", key_level[0], 1'b0);
    step(1);
    check("t1_level_c6", key_level[0], 1'b1);
    check("t1_buttons_c6", buttons, 4'b0000);
    step(1);
    check("t1_buttons_c7", buttons, 4'b0001);
    step(1);
    check("t1_buttons_c8", buttons, 4'b0000);
`ifndef KEY_AUTO_REPEAT_EN
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (buttons != 0) n++;
    end
    check("t1_no_repeat", n, 0);
`endif
    key_raw = '0;
    step(14);

    // 2: bouncing left press
    key_raw[2] = 1'b1; step(1);
    key_raw[2] = 1'b0; step(1);
    key_raw[2] = 1'b1; step(1);
    key_raw[2] = 1'b0; step(1);
    key_raw[2] = 1'b1;
    n = 0; first = -1;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (buttons != 0) begin
        n++;
        if (first < 0) first = i;
        check("t2_code", buttons, 4'b0100);
      end
    end
    check("t2_count", n, 1);
    check("t2_delay", first, 7);
    key_raw = '0;
    step(14);

    // 3: up, right and confirm together
    key_raw = 5'b11001;
    step(7);
    check("t3_up", {btn, buttons}, 5'b00001);
    step(1);
    check("t3_right", {btn, buttons}, 5'b01000);
    step(1);
    check("t3_confirm", {btn, buttons}, 5'b10000);
    step(1);
    check("t3_idle", {btn, buttons}, 5'b00000);
    key_raw = '0;
    step(20);

    // 4: reset while down's counter is at its last count
    key_raw[1] = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    check("t4_level_in_rst", key_level, 5'b00000);
    check("t4_out_in_rst", {btn, buttons}, 5'b00000);
    rst = 1'b0;
    n = 0; first = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (buttons != 0 || btn) begin
        n++;
        if (first < 0) first = i;
        check("t4_code", {btn, buttons}, 5'b00010);
      end
    end
    check("t4_count", n, 1);
    check("t4_delay", first, 7);
    key_raw = '0;
    step(14);

`ifdef KEY_AUTO_REPEAT_EN
    // 5: right held with auto-repeat, then released
    key_raw[3] = 1'b1;
    pulse_at.delete();
    for (int i = 1; i <= 24; i++) begin
      step(1);
      if (buttons != 0) begin
        pulse_at.push_back(i);
        check("t5_code", buttons, 4'b1000);
      end
    end
    check("t5_count", pulse_at.size(), 4);
    if (pulse_at.size() == 4) begin
      check("t5_p0", pulse_at[0], 7);
      check("t5_p1", pulse_at[1], 17);
      check("t5_p2", pulse_at[2], 20);
      check("t5_p3", pulse_at[3], 23);
    end
    key_raw[3] = 1'b0;
    step(5);
    check("t5_level_before_fall", key_level[3], 1'b1);
    step(1);
    check("t5_level_fall", key_level[3], 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (buttons != 0) n++;
    end
    check("t5_stopped", n, 0);

    // 6: confirm never repeats
    key_raw[4] = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (btn) n++;
    end
    check("t6_confirm_once", n, 1);
    key_raw = '0;
    step(14);
`endif

    // Random phase: sticky keys with occasional glitches and resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(11) == 0) key_raw[k] = ~key_raw[k];
      end
      rst = ($urandom_range(399) == 0);
    end
    rst     = 1'b0;
    key_raw = '0;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
